// File: rtl/tick_gen_pkg.sv
// Shared definitions for the tick generator: channel mode encoding and default divisor.
package tick_gen_pkg;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  localparam int unsigned DEFAULT_DIV = 100_000_000;

endpackage

// File: rtl/tick_chan.sv
// One tick channel: divisor counter with a shadowed divisor that is swapped in at terminal count.
// Define TICK_GEN_ONESHOT_EN to add the one-shot mode.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int          WIDTH    = 27,
  parameter int unsigned INIT_DIV = 100_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_div,
`ifdef TICK_GEN_ONESHOT_EN
  input  logic             wr_mode,
`endif
  output logic             tick,
  output logic             busy
);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] shadow_div_reg;
  logic             pending_reg;
  logic             tick_reg;
  logic             hold;
  logic             terminal;
  logic             apply;

`ifdef TICK_GEN_ONESHOT_EN
  mode_e mode_reg;
  mode_e shadow_mode_reg;
  logic  done_reg;

  assign hold = done_reg;
`else
  assign hold = 1'b0;
`endif

  // A spent one-shot is parked, so it takes updates as if it were disabled.
  assign terminal = enable && !hold && (cnt_reg == div_reg);
  assign apply    = pending_reg && (terminal || !enable || hold);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg        <= '0;
      div_reg        <= WIDTH'(INIT_DIV);
      shadow_div_reg <= WIDTH'(INIT_DIV);
      pending_reg    <= 1'b0;
      tick_reg       <= 1'b0;
    end else begin
      if (!enable || hold) begin
        cnt_reg  <= '0;
        tick_reg <= 1'b0;
      end else if (terminal) begin
        cnt_reg  <= '0;
        tick_reg <= 1'b1;
      end else begin
        cnt_reg  <= cnt_reg + 1'b1;
        tick_reg <= 1'b0;
      end
      // Writes are only accepted while nothing is pending, so apply and load never collide.
      if (apply) begin
        div_reg     <= shadow_div_reg;
        pending_reg <= 1'b0;
      end else if (wr_en) begin
        shadow_div_reg <= wr_div;
        pending_reg    <= 1'b1;
      end
    end
  end

`ifdef TICK_GEN_ONESHOT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_reg        <= MODE_PERIODIC;
      shadow_mode_reg <= MODE_PERIODIC;
      done_reg        <= 1'b0;
    end else begin
      if (apply) begin
        mode_reg <= shadow_mode_reg;
        done_reg <= 1'b0;
      end else begin
        done_reg <= enable && (done_reg || (terminal && (mode_reg == MODE_ONESHOT)));
      end
      if (wr_en && !apply) begin
        shadow_mode_reg <= mode_e'(wr_mode);
      end
    end
  end
`endif

  assign tick = tick_reg;
  assign busy = pending_reg;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator: CHANNELS independent tick_chan instances behind one config port.
// Define TICK_GEN_ONESHOT_EN to add cfg_mode and the per-channel one-shot mode.
module tick_gen #(
  parameter int          CHANNELS    = 4,
  parameter int          WIDTH       = 27,
  parameter int unsigned DEFAULT_DIV = tick_gen_pkg::DEFAULT_DIV
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [CHANNELS-1:0]                         enable,
  input  logic                                        cfg_valid,
  output logic                                        cfg_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
  input  logic [WIDTH-1:0]                            cfg_div,
`ifdef TICK_GEN_ONESHOT_EN
  input  logic                                        cfg_mode,
`endif
  output logic [CHANNELS-1:0]                         tick,
  output logic [CHANNELS-1:0]                         busy
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] wr_sel;

  // Unmapped channel numbers read as ready so the write is silently dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CW'(i)) begin
        cfg_ready = !busy[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign wr_sel[gi] = cfg_valid && cfg_ready && (cfg_chan == CW'(gi));

      tick_chan #(
        .WIDTH    (WIDTH),
        .INIT_DIV (DEFAULT_DIV)
      ) u_chan (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable[gi]),
        .wr_en   (wr_sel[gi]),
        .wr_div  (cfg_div),
`ifdef TICK_GEN_ONESHOT_EN
        .wr_mode (cfg_mode),
`endif
        .tick    (tick[gi]),
        .busy    (busy[gi])
      );
    end
  endgenerate

endmodule
